// File: rtl/ct_ibiu_l2csr_req_ctrl.sv
// L2 CSR / L2 RAM debug-access request controller: CP0 request -> CIU CSR strobe, completion -> CP0.
// Optional hang timeout is built only when L2CSR_TIMEOUT_EN is defined.
module ct_ibiu_l2csr_req_ctrl #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic         forever_cpuclk,
    input  logic         cpurst_b,
    input  logic         cp0_biu_l2csr_vld,
    input  logic [15:0]  cp0_biu_l2csr_op,
    input  logic [63:0]  cp0_biu_l2csr_wdata,
    input  logic         cp0_biu_l2csr_kill,
    output logic         biu_cp0_l2csr_rdy,
    output logic         biu_cp0_l2csr_done,
    output logic         biu_cp0_l2csr_err,
    output logic [127:0] biu_cp0_l2csr_rdata,
    output logic         biu_l2csr_busy,
    output logic         ibiu_ciu_csr_sel,
    output logic [79:0]  ibiu_ciu_csr_wdata,
    input  logic         ciu_ibiu_csr_cmplt,
    input  logic [127:0] ciu_ibiu_csr_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         accept;
    logic         timeout_hit;
    logic         done_nxt;
    logic         err_nxt;
    logic         rdata_upd;
    logic [127:0] rdata_nxt;

    assign biu_cp0_l2csr_rdy = (state == ST_IDLE) & ~cp0_biu_l2csr_kill;
    assign accept            = cp0_biu_l2csr_vld & biu_cp0_l2csr_rdy;
    assign biu_l2csr_busy    = (state != ST_IDLE);

`ifdef L2CSR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && !cp0_biu_l2csr_kill
                     && !ciu_ibiu_csr_cmplt && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        rdata_upd = 1'b0;
        rdata_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Kill wins over a same-cycle completion, which is then simply consumed.
                if (cp0_biu_l2csr_kill) begin
                    state_nxt = ciu_ibiu_csr_cmplt ? ST_IDLE : ST_DRAIN;
                end else if (ciu_ibiu_csr_cmplt) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    rdata_upd = 1'b1;
                    // Register reads return only the low doubleword; DCA reads use all 128 bits.
                    rdata_nxt = ibiu_ciu_csr_wdata[79] ? ciu_ibiu_csr_rdata
                                                       : {64'h0, ciu_ibiu_csr_rdata[63:0]};
                end else if (timeout_hit) begin
                    state_nxt = ST_DRAIN;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    rdata_upd = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (ciu_ibiu_csr_cmplt)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state               <= ST_IDLE;
            ibiu_ciu_csr_sel    <= 1'b0;
            ibiu_ciu_csr_wdata  <= '0;
            biu_cp0_l2csr_done  <= 1'b0;
            biu_cp0_l2csr_err   <= 1'b0;
            biu_cp0_l2csr_rdata <= '0;
        end else begin
            state              <= state_nxt;
            ibiu_ciu_csr_sel   <= accept;
            biu_cp0_l2csr_done <= done_nxt;
            biu_cp0_l2csr_err  <= err_nxt;
            if (accept)
                ibiu_ciu_csr_wdata <= {cp0_biu_l2csr_op, cp0_biu_l2csr_wdata};
            if (rdata_upd)
                biu_cp0_l2csr_rdata <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_ct_ibiu_l2csr_req_ctrl.sv
// Bench for ct_ibiu_l2csr_req_ctrl: directed vector table, corner sequences, and random traffic
// checked against a transaction-level model. Build with or without L2CSR_TIMEOUT_EN.
module tb_ct_ibiu_l2csr_req_ctrl;

    localparam int TO = 4;
`ifdef L2CSR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         forever_cpuclk;
    logic         cpurst_b;
    logic         vld;
    logic [15:0]  op;
    logic [63:0]  wd;
    logic         kill;
    logic         rdy;
    logic         done;
    logic         err;
    logic [127:0] rdata;
    logic         busy;
    logic         sel;
    logic [79:0]  cwdata;
    logic         cmplt;
    logic [127:0] crd;

    ct_ibiu_l2csr_req_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
        .forever_cpuclk      (forever_cpuclk),
        .cpurst_b            (cpurst_b),
        .cp0_biu_l2csr_vld   (vld),
        .cp0_biu_l2csr_op    (op),
        .cp0_biu_l2csr_wdata (wd),
        .cp0_biu_l2csr_kill  (kill),
        .biu_cp0_l2csr_rdy   (rdy),
        .biu_cp0_l2csr_done  (done),
        .biu_cp0_l2csr_err   (err),
        .biu_cp0_l2csr_rdata (rdata),
        .biu_l2csr_busy      (busy),
        .ibiu_ciu_csr_sel    (sel),
        .ibiu_ciu_csr_wdata  (cwdata),
        .ciu_ibiu_csr_cmplt  (cmplt),
        .ciu_ibiu_csr_rdata  (crd)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: one outstanding request, either awaiting data or abandoned.
    bit           m_wait;
    bit           m_drain;
    int           m_age;
    logic [79:0]  m_word;
    logic [127:0] m_rdata;
    bit           m_done;
    bit           m_err;
    bit           m_sel;
    logic         last_rdy;

    typedef struct {
        logic         vld;
        logic [15:0]  op;
        logic [63:0]  wd;
        logic         kill;
        logic         cmplt;
        logic [127:0] crd;
        logic         e_rdy;
        logic         e_sel;
        logic         e_busy;
        logic         e_done;
        logic [127:0] e_rdata;
        logic [79:0]  e_wdata;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_drain = 0; m_age = 0; m_word = '0; m_rdata = '0;
        m_done = 0; m_err = 0; m_sel = 0;
    endtask

    task automatic drive(input logic v, input logic [15:0] o, input logic [63:0] w,
                         input logic k, input logic c, input logic [127:0] d);
        vld = v; op = o; wd = w; kill = k; cmplt = c; crd = d;
    endtask

    task automatic step();
        bit acc;
        #1;
        last_rdy = rdy;
        chk("rdy", rdy, !m_wait && !m_drain && !kill);
        acc = vld && !m_wait && !m_drain && !kill;
        m_done = 0;
        m_err  = 0;
        if (m_wait) begin
            if (kill) begin
                m_wait = 0; m_drain = !cmplt;
            end else if (cmplt) begin
                m_wait = 0; m_done = 1;
                m_rdata = m_word[79] ? crd : {64'h0, crd[63:0]};
            end else if (TO_EN && m_age == TO - 1) begin
                m_wait = 0; m_drain = 1; m_done = 1; m_err = 1; m_rdata = '0;
            end else begin
                m_age++;
            end
        end else if (m_drain && cmplt) begin
            m_drain = 0;
        end
        if (acc) begin
            m_wait = 1; m_age = 0; m_word = {op, wd};
        end
        m_sel = acc;
        @(posedge forever_cpuclk);
        #1;
        chk("sel", sel, m_sel);
        chk("csr_wdata", cwdata, m_word);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("rdata", rdata, m_rdata);
        chk("busy", busy, m_wait || m_drain);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_wdata"}, cwdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, rdy, 1);
    endtask

    task automatic add(input logic v, input logic [15:0] o, input logic [63:0] w, input logic k,
                       input logic c, input logic [127:0] d, input logic er, input logic es,
                       input logic eb, input logic ed, input logic [127:0] erd, input logic [79:0] ew);
        vec_t r;
        r = '{v, o, w, k, c, d, er, es, eb, ed, erd, ew};
        tbl.push_back(r);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] r1;
        logic [127:0] dca;
        logic [79:0]  w1;
        logic [79:0]  w2;
        logic [79:0]  w3;
        r1  = {64'h0, 64'hDEAD_BEEF_1234_5678};
        dca = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        w1  = 80'h0015_0000_0000_0000_0000;
        w2  = 80'h0123_0000_0000_0000_00AA;
        w3  = 80'h0200_0000_0000_0000_0000;

        // Register read, kill then late completion, kill with completion, stray completion.
        add(1, 16'h0015, 64'h0,  0, 0, '0, 1, 1, 1, 0, '0, w1);
        add(0, 16'h0,    64'h0,  0, 0, '0, 0, 0, 1, 0, '0, w1);
        add(0, 16'h0,    64'h0,  0, 0, '0, 0, 0, 1, 0, '0, w1);
        add(0, 16'h0,    64'h0,  0, 1, r1, 0, 0, 0, 1, r1, w1);
        add(0, 16'h0,    64'h0,  0, 0, '0, 1, 0, 0, 0, r1, w1);
        add(1, 16'h0123, 64'hAA, 0, 0, '0, 1, 1, 1, 0, r1, w2);
        add(0, 16'h0,    64'h0,  0, 0, '0, 0, 0, 1, 0, r1, w2);
        add(0, 16'h0,    64'h0,  1, 0, '0, 0, 0, 1, 0, r1, w2);
        add(0, 16'h0,    64'h0,  0, 0, '0, 0, 0, 1, 0, r1, w2);
        add(0, 16'h0,    64'h0,  1, 0, '0, 0, 0, 1, 0, r1, w2);
        add(0, 16'h0,    64'h0,  0, 0, '0, 0, 0, 1, 0, r1, w2);
        add(0, 16'h0,    64'h0,  0, 1, '1, 0, 0, 0, 0, r1, w2);
        add(0, 16'h0,    64'h0,  0, 0, '0, 1, 0, 0, 0, r1, w2);
        add(1, 16'h0200, 64'h0,  0, 0, '0, 1, 1, 1, 0, r1, w3);
        add(0, 16'h0,    64'h0,  1, 1, dca, 0, 0, 0, 0, r1, w3);
        add(0, 16'h0,    64'h0,  0, 0, '0, 1, 0, 0, 0, r1, w3);
        add(0, 16'h0,    64'h0,  0, 1, 128'h123, 1, 0, 0, 0, r1, w3);

        cpurst_b = 1'b0;
        drive(0, 0, 0, 0, 0, '0);
        model_reset();
        repeat (2) @(posedge forever_cpuclk);
        #1;
        check_reset_vals("reset");
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].op, tbl[i].wd, tbl[i].kill, tbl[i].cmplt, tbl[i].crd);
            step();
            chk($sformatf("tbl%0d_rdy", i), last_rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_sel", i), sel, tbl[i].e_sel);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_err", i), err, 0);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_wdata", i), cwdata, tbl[i].e_wdata);
        end

        // DCA read with a second request held pending, accepted back-to-back.
        drive(1, 16'h8000, 64'h5_0000_0000, 0, 0, '0);
        step();
        chk("dca_sel", sel, 1);
        chk("dca_word", cwdata, 80'h8000_0000_0005_0000_0000);
        drive(1, 16'h0021, 64'h77, 0, 0, '0);
        step();
        chk("b2b_hold_sel", sel, 0);
        drive(1, 16'h0021, 64'h77, 0, 1, dca);
        step();
        chk("dca_done", done, 1);
        chk("dca_rdata", rdata, dca);
        chk("dca_rdy", rdy, 1);
        drive(1, 16'h0021, 64'h77, 0, 0, '0);
        step();
        chk("b2b_sel", sel, 1);
        chk("b2b_word", cwdata, 80'h0021_0000_0000_0000_0077);
        drive(0, 0, 0, 0, 1, dca);
        step();
        chk("reg_mask_rdata", rdata, {64'h0, dca[63:0]});

`ifdef L2CSR_TIMEOUT_EN
        drive(1, 16'h0010, 64'h0, 0, 0, '0);
        step();
        drive(0, 0, 0, 0, 0, '0);
        repeat (3) begin
            step();
            chk("to_early_done", done, 0);
        end
        step();
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 0);
        repeat (4) begin
            step();
            chk("to_drain_busy", busy, 1);
        end
        drive(0, 0, 0, 0, 1, dca);
        step();
        chk("to_late_done", done, 0);
        chk("to_late_rdata", rdata, 0);
        drive(0, 0, 0, 0, 0, '0);
        step();
        chk("to_rdy_after", last_rdy, 1);
        drive(1, 16'h8010, 64'h0, 0, 0, '0);
        step();
        drive(0, 0, 0, 0, 0, '0);
        repeat (3) step();
        drive(0, 0, 0, 0, 1, dca);
        step();
        chk("to_coinc_done", done, 1);
        chk("to_coinc_err", err, 0);
        chk("to_coinc_rdata", rdata, dca);
`else
        drive(1, 16'h0010, 64'h0, 0, 0, '0);
        step();
        drive(0, 0, 0, 0, 0, '0);
        repeat (10) begin
            step();
            chk("noto_done", done, 0);
            chk("noto_busy", busy, 1);
        end
        drive(0, 0, 0, 0, 1, dca);
        step();
        chk("noto_cmplt_done", done, 1);
        chk("noto_cmplt_err", err, 0);
`endif

        // Reset while a request is outstanding.
        drive(1, 16'h0033, 64'h99, 0, 0, '0);
        step();
        drive(0, 0, 0, 0, 0, '0);
        step();
        cpurst_b = 1'b0;
        #1;
        check_reset_vals("rst_wait");
        model_reset();
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        drive(0, 0, 0, 0, 1, dca);
        step();
        chk("rst_stray_done", done, 0);
        chk("rst_stray_rdata", rdata, 0);
        drive(1, 16'h0044, 64'h1, 0, 0, '0);
        step();
        chk("rst_new_sel", sel, 1);
        drive(0, 0, 0, 0, 1, r1);
        step();
        chk("rst_new_done", done, 1);
        chk("rst_new_rdata", rdata, r1);

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1) == 1, 16'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  {$urandom, $urandom, $urandom, $urandom});
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
